// File: rtl/hazard_ctrl.sv
// hazard_ctrl: F/D/E/M pipeline sequencing controller.
// Tracks stage valid bits and drives stall/kill/redirect/writeback enables.
module hazard_ctrl #(
    parameter int MUL_LAT     = 4,
    parameter int BOOT_CYCLES = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] instr_d,
    input  logic [31:0] instr_e,
    input  logic [31:0] instr_m,
    input  logic        br_cond,
    input  logic        dmem_ready,
    output logic        dmem_valid,
    output logic        stall_f,
    output logic        stall_d,
    output logic        stall_e,
    output logic        kill_d,
    output logic        kill_e,
    output logic        branch_taken,
    output logic        wr_en
);

    localparam int CW = (MUL_LAT > 1) ? $clog2(MUL_LAT) : 1;
    localparam int BW = $clog2(BOOT_CYCLES + 1);

    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_IMM    = 7'b0010011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] F7_MULDIV  = 7'b0000001;

    typedef enum logic [1:0] {
        S_BOOT,
        S_RUN,
        S_MUL,
        S_MEM
    } state_t;

    state_t state;
    state_t state_nx;

    logic          v_d;
    logic          v_e;
    logic          v_m;
    logic [CW-1:0] mul_cnt;
    logic [BW-1:0] boot_cnt;

    logic [6:0] op_d;
    logic [6:0] op_e;
    logic [6:0] op_m;
    logic [4:0] rs1_d;
    logic [4:0] rs2_d;
    logic [4:0] rd_e;
    logic [4:0] rd_m;

    logic use_rs2_d;
    logic ld_e;
    logic mul_e;
    logic jmp_e;
    logic br_e;
    logic wr_m;
    logic mul_last;
    logic dmem_req;
    logic mem_stall;
    logic ex_stall;
    logic take_br;
    logic lu_raw;
    logic load_use;
    logic unused_bits;

    assign op_d  = instr_d[6:0];
    assign op_e  = instr_e[6:0];
    assign op_m  = instr_m[6:0];
    assign rs1_d = instr_d[19:15];
    assign rs2_d = instr_d[24:20];
    assign rd_e  = instr_e[11:7];
    assign rd_m  = instr_m[11:7];

    assign unused_bits = ^{instr_d[31:25], instr_d[14:7],
                           instr_e[24:12], instr_m[31:12]};

    assign use_rs2_d = (op_d == OPC_OP) | (op_d == OPC_STORE) |
                       (op_d == OPC_BRANCH);
    assign ld_e  = (op_e == OPC_LOAD);
    assign mul_e = (op_e == OPC_OP) & (instr_e[31:25] == F7_MULDIV);
    assign jmp_e = (op_e == OPC_JAL) | (op_e == OPC_JALR);
    assign br_e  = (op_e == OPC_BRANCH);

    // register-writing opcode classes seen in M
    always_comb begin
        wr_m = 1'b0;
        unique case (op_m)
            OPC_OP, OPC_IMM, OPC_LOAD, OPC_LUI,
            OPC_AUIPC, OPC_JAL, OPC_JALR: wr_m = 1'b1;
            default:                      wr_m = 1'b0;
        endcase
    end

    assign dmem_req  = v_m & ((op_m == OPC_LOAD) | (op_m == OPC_STORE));
    assign mem_stall = dmem_req & ~dmem_ready;
    assign mul_last  = (mul_cnt == CW'(MUL_LAT - 1));
    assign ex_stall  = ~mem_stall & v_e & mul_e & ~mul_last;
    assign take_br   = ~mem_stall & ~ex_stall & v_e &
                       (jmp_e | (br_e & br_cond));
    assign lu_raw    = v_d & v_e & ld_e & (rd_e != 5'd0) &
                       ((rd_e == rs1_d) | ((rd_e == rs2_d) & use_rs2_d));
    assign load_use  = ~mem_stall & ~ex_stall & ~take_br & lu_raw;

    // stage valid bits follow the stall/kill decisions of this cycle
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            v_d <= 1'b0;
            v_e <= 1'b0;
            v_m <= 1'b0;
        end else begin
            v_d <= ~kill_d;
            v_e <= stall_e ? v_e : (v_d & ~kill_e);
            v_m <= mem_stall ? v_m : (v_e & ~ex_stall);
        end
    end

    // multiply occupancy in E, frozen while memory holds the pipe
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            mul_cnt <= '0;
        end else if (!mem_stall) begin
            if (v_e & mul_e & ~mul_last) begin
                mul_cnt <= mul_cnt + CW'(1);
            end else begin
                mul_cnt <= '0;
            end
        end
    end

    // post-reset countdown that keeps D/E flushed
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            boot_cnt <= BW'(BOOT_CYCLES);
        end else if (state == S_BOOT && boot_cnt != '0) begin
            boot_cnt <= boot_cnt - BW'(1);
        end
    end

    // state register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= S_BOOT;
        end else begin
            state <= state_nx;
        end
    end

    // next state: leave BOOT as the countdown hits zero
    always_comb begin
        state_nx = state;
        case (state)
            S_BOOT: begin
                if (boot_cnt <= BW'(1)) begin
                    state_nx = S_RUN;
                end
            end
            default: begin
                if (mem_stall) begin
                    state_nx = S_MEM;
                end else if (ex_stall) begin
                    state_nx = S_MUL;
                end else begin
                    state_nx = S_RUN;
                end
            end
        endcase
    end

    // outputs: one hazard class acts per cycle, highest priority first
    always_comb begin
        dmem_valid   = 1'b0;
        stall_f      = 1'b0;
        stall_d      = 1'b0;
        stall_e      = 1'b0;
        kill_d       = 1'b0;
        kill_e       = 1'b0;
        branch_taken = 1'b0;
        wr_en        = 1'b0;
        if (state == S_BOOT) begin
            kill_d = 1'b1;
            kill_e = 1'b1;
        end else begin
            unique case (1'b1)
                mem_stall, ex_stall: begin
                    stall_f = 1'b1;
                    stall_d = 1'b1;
                    stall_e = 1'b1;
                end
                take_br: begin
                    branch_taken = 1'b1;
                    kill_d       = 1'b1;
                    kill_e       = 1'b1;
                end
                load_use: begin
                    stall_f = 1'b1;
                    stall_d = 1'b1;
                    kill_e  = 1'b1;
                end
                default: ;
            endcase
            dmem_valid = dmem_req;
            wr_en      = v_m & wr_m & (rd_m != 5'd0) & ~mem_stall;
        end
    end

endmodule

// File: tb/tb_hazard_ctrl.sv
// tb_hazard_ctrl: program-driven bench with a pipeline-occupancy model.
// The bench plays the datapath: it holds F/D/E/M contents and obeys its model.
module tb_hazard_ctrl;

    localparam int ML = 4;
    localparam int BC = 2;
    localparam int PN = 48;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic [31:0] instr_d = 32'h0;
    logic [31:0] instr_e = 32'h0;
    logic [31:0] instr_m = 32'h0;
    logic br_cond = 1'b0;
    logic dmem_ready = 1'b1;
    logic dmem_valid, stall_f, stall_d, stall_e;
    logic kill_d, kill_e, branch_taken, wr_en;

    always #5 clk = ~clk;

    hazard_ctrl #(.MUL_LAT(ML), .BOOT_CYCLES(BC)) dut (
        .clk(clk), .rst(rst),
        .instr_d(instr_d), .instr_e(instr_e), .instr_m(instr_m),
        .br_cond(br_cond), .dmem_ready(dmem_ready),
        .dmem_valid(dmem_valid), .stall_f(stall_f), .stall_d(stall_d),
        .stall_e(stall_e), .kill_d(kill_d), .kill_e(kill_e),
        .branch_taken(branch_taken), .wr_en(wr_en)
    );

    typedef struct {
        logic [31:0] ins;
        bit          br;
        int          off;
        int          wt;
    } op_t;

    op_t prog[PN];
    int  np;
    int  tests = 0;
    int  fails = 0;

    // model of pipeline occupancy (program indices, -1 = empty)
    int  d_i, e_i, m_i, pc, age, mwait, boot_left, cyc;
    bit  vd, ve, vm;

    // observations for the literal pins
    bit  log_en = 1'b0;
    int  wcount[32];
    int  first_wr, lu_n, ms_n, ex_n, br_n;
    bit  bootk[4];

    function automatic logic [31:0] i_addi(int rd, int rs1, int imm);
        return {12'(imm), 5'(rs1), 3'b000, 5'(rd), 7'h13};
    endfunction
    function automatic logic [31:0] i_lw(int rd, int rs1);
        return {12'd0, 5'(rs1), 3'b010, 5'(rd), 7'h03};
    endfunction
    function automatic logic [31:0] i_sw(int rs2, int rs1);
        return {7'd0, 5'(rs2), 5'(rs1), 3'b010, 5'd0, 7'h23};
    endfunction
    function automatic logic [31:0] i_rr(int f7, int rd, int rs1, int rs2);
        return {7'(f7), 5'(rs2), 5'(rs1), 3'b000, 5'(rd), 7'h33};
    endfunction
    function automatic logic [31:0] i_beq(int rs1, int rs2);
        return {7'd0, 5'(rs2), 5'(rs1), 3'b000, 5'd0, 7'h63};
    endfunction
    function automatic logic [31:0] i_jal(int rd);
        return {20'd0, 5'(rd), 7'h6F};
    endfunction

    task automatic put(input logic [31:0] ins, input bit br = 1'b0,
                       input int off = 0, input int wt = 0);
        prog[np].ins = ins;
        prog[np].br  = br;
        prog[np].off = off;
        prog[np].wt  = wt;
        np++;
    endtask

    function automatic logic [31:0] at(int i);
        if (i < 0) return 32'h0;
        if (i >= PN) return 32'h13;
        return prog[i].ins;
    endfunction
    function automatic bit brc(int i);
        return (i >= 0 && i < PN) ? prog[i].br : 1'b0;
    endfunction
    function automatic int wt_of(int i);
        return (i >= 0 && i < PN) ? prog[i].wt : 0;
    endfunction
    function automatic int off_of(int i);
        return (i >= 0 && i < PN) ? prog[i].off : 1;
    endfunction
    function automatic bit writes(logic [31:0] x);
        case (x[6:0])
            7'h33, 7'h13, 7'h03, 7'h37, 7'h17, 7'h6F, 7'h67: return 1'b1;
            default: return 1'b0;
        endcase
    endfunction
    function automatic bit uses2(logic [31:0] x);
        return x[6:0] == 7'h33 || x[6:0] == 7'h23 || x[6:0] == 7'h63;
    endfunction

    task automatic chk(input string nm, input int got, input int exp);
        tests++;
        if (got != exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)",
                     nm, got, exp, cyc);
        end
    endtask

    task automatic model_reset();
        d_i = -1; e_i = -1; m_i = -1;
        vd = 0; ve = 0; vm = 0;
        pc = 0; age = 0; mwait = 0;
        boot_left = BC; cyc = 0;
    endtask

    task automatic step(input bit r);
        logic [31:0] id, ie, im;
        bit x_dv, x_sf, x_sd, x_se, x_kd, x_ke, x_br, x_wr;
        bit mstall, exs, lu;
        int nd, ne, nm;
        bit nvd, nve, nvm;
        @(negedge clk);
        rst = r;
        if (!r) model_reset();
        else cyc++;
        id = at(d_i); ie = at(e_i); im = at(m_i);
        instr_d = id; instr_e = ie; instr_m = im;
        br_cond = brc(e_i);
        dmem_ready = (mwait == 0);
        #1;
        {x_dv, x_sf, x_sd, x_se, x_kd, x_ke, x_br, x_wr} = '0;
        {mstall, exs, lu} = '0;
        if (!r || boot_left > 0) begin
            x_kd = 1; x_ke = 1;
        end else begin
            x_dv   = vm && (im[6:0] == 7'h03 || im[6:0] == 7'h23);
            mstall = x_dv && (mwait != 0);
            exs    = !mstall && ve && ie[6:0] == 7'h33 &&
                     ie[31:25] == 7'd1 && age < ML - 1;
            x_br   = !mstall && !exs && ve &&
                     (ie[6:0] == 7'h6F || ie[6:0] == 7'h67 ||
                      (ie[6:0] == 7'h63 && brc(e_i)));
            lu     = !mstall && !exs && !x_br && vd && ve &&
                     ie[6:0] == 7'h03 && ie[11:7] != 0 &&
                     (ie[11:7] == id[19:15] ||
                      (ie[11:7] == id[24:20] && uses2(id)));
            x_sf = mstall || exs || lu;
            x_sd = x_sf;
            x_se = mstall || exs;
            x_kd = x_br;
            x_ke = x_br || lu;
            x_wr = vm && writes(im) && im[11:7] != 0 && !mstall;
        end
        chk("dmem_valid", int'(dmem_valid), int'(x_dv));
        chk("stall_f", int'(stall_f), int'(x_sf));
        chk("stall_d", int'(stall_d), int'(x_sd));
        chk("stall_e", int'(stall_e), int'(x_se));
        chk("kill_d", int'(kill_d), int'(x_kd));
        chk("kill_e", int'(kill_e), int'(x_ke));
        chk("branch_taken", int'(branch_taken), int'(x_br));
        chk("wr_en", int'(wr_en), int'(x_wr));
        if (r && log_en) begin
            if (wr_en) wcount[instr_m[11:7]]++;
            if (wr_en && first_wr == 0) first_wr = cyc;
            if (cyc <= 3) bootk[cyc] = kill_d;
            if (stall_d && !stall_e) lu_n++;
            if (dmem_valid && !dmem_ready) ms_n++;
            if (stall_e && !(dmem_valid && !dmem_ready)) ex_n++;
            if (branch_taken) br_n++;
        end
        if (r) begin
            nd  = x_sd ? d_i : pc;
            ne  = x_se ? e_i : d_i;
            nm  = mstall ? m_i : e_i;
            nvd = !x_kd;
            nve = x_se ? ve : (vd && !x_ke);
            nvm = mstall ? vm : (ve && !exs);
            if (!x_se) age = 0;
            else if (!mstall) age++;
            if (mstall) mwait--;
            else mwait = nvm ? wt_of(nm) : 0;
            if (x_br) pc = e_i + off_of(e_i);
            else if (!x_sf) pc++;
            if (boot_left > 0) boot_left--;
            d_i = nd; e_i = ne; m_i = nm;
            vd = nvd; ve = nve; vm = nvm;
        end
    endtask

    int once_r[17] = '{1, 5, 6, 7, 10, 3, 11, 12, 13, 14,
                       17, 18, 19, 21, 22, 23, 24};
    int never_r[8] = '{0, 2, 8, 9, 15, 16, 25, 26};

    initial begin
        np = 0;
        put(32'h13); put(32'h13);
        put(i_addi(1, 0, 1));
        put(i_lw(5, 1));
        put(i_rr(0, 6, 5, 2));
        put(32'h13);
        put(i_addi(0, 0, 1));
        put(i_lw(0, 1));
        put(i_rr(0, 7, 0, 0));
        put(i_beq(1, 2), 1'b1, 3);
        put(i_addi(8, 0, 1));
        put(i_addi(9, 0, 1));
        put(i_beq(1, 2), 1'b0, 3);
        put(i_addi(10, 0, 1));
        put(i_rr(1, 3, 4, 5));
        put(i_addi(11, 0, 1));
        put(i_lw(12, 1), 1'b0, 0, 5);
        put(i_addi(13, 0, 2));
        put(i_sw(2, 1), 1'b0, 0, 2);
        put(i_jal(14), 1'b0, 3);
        put(i_addi(15, 0, 1));
        put(i_addi(16, 0, 1));
        put(i_rr(1, 17, 3, 3));
        put(i_lw(18, 1));
        put(i_sw(18, 2));
        put(i_lw(19, 1));
        put(i_addi(21, 2, 19));
        put(i_sw(1, 2), 1'b0, 0, 3);
        put(i_rr(1, 22, 1, 1));
        put(i_lw(23, 1), 1'b0, 0, 2);
        put(i_jal(24), 1'b0, 3);
        put(i_addi(25, 0, 1));
        put(i_addi(26, 0, 1));
        while (np < PN) put(32'h13);

        model_reset();
        repeat (3) step(1'b0);
        repeat (14) step(1'b1);
        repeat (2) step(1'b0);

        foreach (wcount[i]) wcount[i] = 0;
        foreach (bootk[i]) bootk[i] = 0;
        first_wr = 0; lu_n = 0; ms_n = 0; ex_n = 0; br_n = 0;
        log_en = 1'b1;
        begin
            int n;
            n = 0;
            while (pc < 46 && n < 400) begin
                step(1'b1);
                n++;
            end
            chk("drain_budget", int'(n < 400), 1);
        end
        repeat (4) step(1'b1);

        chk("boot_kill_c1", int'(bootk[1]), 1);
        chk("boot_kill_c2", int'(bootk[2]), 1);
        chk("boot_kill_c3", int'(bootk[3]), 0);
        chk("first_wr_cycle", first_wr, 6);
        chk("load_use_bubbles", lu_n, 2);
        chk("mul_stall_cycles", ex_n, 9);
        chk("mem_stall_cycles", ms_n, 12);
        chk("branches_taken", br_n, 3);
        foreach (once_r[i]) chk($sformatf("writes_x%0d", once_r[i]),
                                wcount[once_r[i]], 1);
        foreach (never_r[i]) chk($sformatf("writes_x%0d", never_r[i]),
                                 wcount[never_r[i]], 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
